// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage-register state encoding, per-stage payload
// structs and their packed widths so stage instantiations can size DATA_W.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_FULL  = 2'd1,
    PS_SKID  = 2'd2
  } pstage_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_t;

  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  localparam int PSTAGE_DATA_W = 128;
  localparam int PSTAGE_CNT_W  = 16;

  // A stage is stalled when it presents a payload that downstream refuses.
  function automatic logic stage_stalled(input logic valid, input logic ready);
    return valid && !ready;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import cpu_types_pkg::*;
#(
  parameter int W = PSTAGE_CNT_W
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_next = count_reg + ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with optional skid entry, synchronous
// flush (bubble insertion) and a saturating stall counter.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int               DATA_W    = PSTAGE_DATA_W,
  parameter bit               SKID      = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = PSTAGE_CNT_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  pstage_state_t     state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              in_hs;
  logic              out_hs;

  assign out_valid = (state_reg != PS_EMPTY);
  assign out_data  = main_reg;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      // The downstream handshake still completes; everything held or offered is dropped.
      state_next = PS_EMPTY;
      main_next  = RESET_VAL;
      skid_next  = RESET_VAL;
    end else begin
      case (state_reg)
        PS_EMPTY: begin
          if (in_hs) begin
            main_next  = in_data;
            state_next = PS_FULL;
          end
        end
        PS_FULL: begin
          if (in_hs && out_hs) begin
            main_next = in_data;
          end else if (out_hs) begin
            main_next  = RESET_VAL;
            state_next = PS_EMPTY;
          end else if (in_hs && SKID) begin
            skid_next  = in_data;
            state_next = PS_SKID;
          end
        end
        PS_SKID: begin
          if (out_hs) begin
            main_next  = skid_reg;
            skid_next  = RESET_VAL;
            state_next = PS_FULL;
          end
        end
        default: begin
          state_next = PS_EMPTY;
          main_next  = RESET_VAL;
          skid_next  = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= PS_EMPTY;
      main_reg  <= RESET_VAL;
      skid_reg  <= RESET_VAL;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  generate
    if (SKID) begin : g_skid_ready
      // Registered ready: only the skid state refuses input, so it can be precomputed.
      logic in_ready_reg;
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != PS_SKID);
        end
      end
      assign in_ready = in_ready_reg;
    end else begin : g_comb_ready
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stage_stalled(out_valid, out_ready)),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid/4-bit-counter instance (dut 0) and a
// no-skid/16-bit-counter instance (dut 1), checked against a FIFO model.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV_A = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        nrst;
  logic        iv  [2];
  logic        orr [2];
  logic        fl  [2];
  logic        cl  [2];
  logic [31:0] id  [2];
  logic        ov  [2];
  logic        ir  [2];
  logic [31:0] od  [2];
  logic [3:0]  sc_a;
  logic [15:0] sc_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each stage is a FIFO (capacity 2 with skid, 1 without).
  logic [31:0] m_ent [2][2];
  int          m_cnt [2];
  int          m_sc  [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(32), .SKID(1'b1), .RESET_VAL(RV_A), .CNT_W(4)
  ) u_dut_a (
    .CLK(clk), .nRST(nrst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od[0]),
    .flush(fl[0]), .clr_cnt(cl[0]), .stall_cnt(sc_a)
  );

  pipe_stage_reg #(
    .DATA_W(32), .SKID(1'b0), .CNT_W(16)
  ) u_dut_b (
    .CLK(clk), .nRST(nrst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od[1]),
    .flush(fl[1]), .clr_cnt(cl[1]), .stall_cnt(sc_b)
  );

  function automatic logic [31:0] rv(input int d);
    return (d == 0) ? RV_A : 32'h0;
  endfunction

  function automatic logic e_ov(input int d);
    return m_cnt[d] > 0;
  endfunction

  function automatic logic [31:0] e_od(input int d);
    return (m_cnt[d] > 0) ? m_ent[d][0] : rv(d);
  endfunction

  function automatic logic e_ir(input int d);
    if (d == 0) return m_cnt[0] < 2;
    return (m_cnt[1] == 0) || orr[1];
  endfunction

  function automatic logic [15:0] a_sc(input int d);
    return (d == 0) ? {12'h0, sc_a} : sc_b;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0;
      m_sc[d]  = 0;
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; orr[d] = 1'b0; fl[d] = 1'b0; cl[d] = 1'b0; id[d] = '0;
    end
  endtask

  task automatic drive(input int d, input bit v, input logic [31:0] dat,
                       input bit o, input bit f, input bit c);
    iv[d] = v; id[d] = dat; orr[d] = o; fl[d] = f; cl[d] = c;
    #1;
  endtask

  // Advance one clock and update the model from the inputs presented before the edge.
  task automatic tick();
    bit          hin [2];
    bit          hout[2];
    bit          st  [2];
    bit          flv [2];
    bit          clv [2];
    logic [31:0] din [2];
    for (int d = 0; d < 2; d++) begin
      hin[d]  = iv[d] && e_ir(d);
      hout[d] = e_ov(d) && orr[d];
      st[d]   = e_ov(d) && !orr[d];
      flv[d]  = fl[d];
      clv[d]  = cl[d];
      din[d]  = id[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (hout[d]) begin
        $display("[TB] dut%0d out 0x%08h", d, m_ent[d][0]);
        m_ent[d][0] = m_ent[d][1];
        m_cnt[d]--;
      end
      if (flv[d]) begin
        m_cnt[d] = 0;
      end else if (hin[d]) begin
        m_ent[d][m_cnt[d]] = din[d];
        m_cnt[d]++;
      end
      if (clv[d]) m_sc[d] = 0;
      else if (st[d] && m_sc[d] < ((d == 0) ? 15 : 65535)) m_sc[d]++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d got %b exp 0", d, ov[d]); end
      n_tests++; if (od[d] !== rv(d)) begin n_fail++; $display("FAIL reset_data dut%0d got 0x%08h exp 0x%08h", d, od[d], rv(d)); end
      n_tests++; if (ir[d] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d got %b exp 1", d, ir[d]); end
      n_tests++; if (a_sc(d) !== 16'd0) begin n_fail++; $display("FAIL reset_cnt dut%0d got %0d exp 0", d, a_sc(d)); end
    end
  endtask

  task automatic test_stream();
    idle_all();
    for (int i = 0; i < 10; i++) begin
      drive(0, i < 8, 32'(i + 1), 1'b1, 1'b0, 1'b0);
      if (i >= 1 && i <= 8) begin
        n_tests++; if (ov[0] !== 1'b1 || od[0] !== 32'(i)) begin
          n_fail++; $display("FAIL stream_out cyc%0d got v=%b 0x%08h exp v=1 0x%08h", i, ov[0], od[0], 32'(i));
        end
      end else begin
        n_tests++; if (ov[0] !== 1'b0 || od[0] !== RV_A) begin
          n_fail++; $display("FAIL stream_idle cyc%0d got v=%b 0x%08h exp v=0 0x%08h", i, ov[0], od[0], RV_A);
        end
      end
      n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL stream_ready cyc%0d got %b exp 1", i, ir[0]); end
      tick();
    end
    n_tests++; if (sc_a !== 4'd0) begin n_fail++; $display("FAIL stream_cnt got %0d exp 0", sc_a); end
  endtask

  task automatic test_skid();
    logic [31:0] exp_seq [3];
    exp_seq[0] = 32'hA; exp_seq[1] = 32'hB; exp_seq[2] = 32'hC;
    idle_all();
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1); tick();
    drive(0, 1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
    n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL skid_accept_a got %b exp 1", ir[0]); end
    tick();
    drive(0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
    n_tests++; if (ir[0] !== 1'b1) begin n_fail++; $display("FAIL skid_accept_b got %b exp 1", ir[0]); end
    tick();
    drive(0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
    n_tests++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL skid_refuse_c got %b exp 0", ir[0]); end
    tick();
    n_tests++; if (sc_a !== 4'd2) begin n_fail++; $display("FAIL skid_stall_cnt got %0d exp 2", sc_a); end
    for (int j = 0; j < 4; j++) begin
      drive(0, j < 2, 32'hC, 1'b1, 1'b0, 1'b0);
      if (j < 3) begin
        n_tests++; if (ov[0] !== 1'b1 || od[0] !== exp_seq[j]) begin
          n_fail++; $display("FAIL skid_drain%0d got v=%b 0x%08h exp v=1 0x%08h", j, ov[0], od[0], exp_seq[j]);
        end
      end else begin
        n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL skid_drained got %b exp 0", ov[0]); end
      end
      if (j == 0) begin
        n_tests++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL skid_ready_hold got %b exp 0", ir[0]); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    idle_all();
    drive(0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1); tick();
    drive(0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0); tick();
    drive(0, 1'b1, 32'hD, 1'b0, 1'b1, 1'b0);
    n_tests++; if (ir[0] !== 1'b0) begin n_fail++; $display("FAIL flush_in_skid got ready %b exp 0", ir[0]); end
    tick();
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (ov[0] !== 1'b0 || od[0] !== RV_A || ir[0] !== 1'b1) begin
      n_fail++; $display("FAIL flush_bubble got v=%b 0x%08h r=%b exp v=0 0x%08h r=1", ov[0], od[0], ir[0], RV_A);
    end
    n_tests++; if (sc_a !== 4'd2) begin n_fail++; $display("FAIL flush_stall_cnt got %0d exp 2", sc_a); end
    for (int j = 0; j < 3; j++) begin
      tick();
      drive(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL flush_no_d cyc%0d got v=%b 0x%08h exp v=0", j, ov[0], od[0]); end
    end
    tick();
  endtask

  task automatic test_saturate();
    idle_all();
    drive(0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1); tick();
    for (int j = 0; j < 20; j++) begin
      drive(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    end
    n_tests++; if (sc_a !== 4'd15) begin n_fail++; $display("FAIL sat_cnt got %0d exp 15", sc_a); end
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    n_tests++; if (sc_a !== 4'd0) begin n_fail++; $display("FAIL sat_clear got %0d exp 0", sc_a); end
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    n_tests++; if (sc_a !== 4'd1) begin n_fail++; $display("FAIL sat_resume got %0d exp 1", sc_a); end
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
  endtask

  task automatic test_noskid();
    idle_all();
    drive(1, 1'b1, 32'h71, 1'b0, 1'b0, 1'b0);
    n_tests++; if (ir[1] !== 1'b1) begin n_fail++; $display("FAIL noskid_empty_ready got %b exp 1", ir[1]); end
    tick();
    drive(1, 1'b1, 32'h72, 1'b0, 1'b0, 1'b0);
    n_tests++; if (ir[1] !== 1'b0) begin n_fail++; $display("FAIL noskid_full_ready got %b exp 0", ir[1]); end
    tick();
    drive(1, 1'b1, 32'h72, 1'b1, 1'b0, 1'b0);
    n_tests++; if (ir[1] !== 1'b1 || od[1] !== 32'h71) begin
      n_fail++; $display("FAIL noskid_pass got r=%b 0x%08h exp r=1 0x00000071", ir[1], od[1]);
    end
    tick();
    drive(1, 1'b1, 32'h73, 1'b1, 1'b0, 1'b0);
    n_tests++; if (od[1] !== 32'h72) begin n_fail++; $display("FAIL noskid_second got 0x%08h exp 0x00000072", od[1]); end
    tick();
    drive(1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (od[1] !== 32'h73) begin n_fail++; $display("FAIL noskid_third got 0x%08h exp 0x00000073", od[1]); end
    tick();
    n_tests++; if (ov[1] !== 1'b0 || od[1] !== 32'h0) begin
      n_fail++; $display("FAIL noskid_empty got v=%b 0x%08h exp v=0 0x00000000", ov[1], od[1]);
    end
    n_tests++; if (sc_b !== 16'd1) begin n_fail++; $display("FAIL noskid_stall_cnt got %0d exp 1", sc_b); end
  endtask

  task automatic test_async_reset();
    idle_all();
    drive(0, 1'b1, 32'h91, 1'b0, 1'b0, 1'b0); tick();
    drive(0, 1'b1, 32'h92, 1'b0, 1'b0, 1'b0); tick();
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 nrst = 1'b0;
    #1;
    n_tests++; if (ov[0] !== 1'b0 || od[0] !== RV_A || ir[0] !== 1'b1 || sc_a !== 4'd0) begin
      n_fail++; $display("FAIL async_reset got v=%b 0x%08h r=%b c=%0d exp v=0 0x%08h r=1 c=0", ov[0], od[0], ir[0], sc_a, RV_A);
    end
    @(negedge clk);
    nrst = 1'b1;
    model_reset();
    drive(0, 1'b1, 32'h93, 1'b1, 1'b0, 1'b0); tick();
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_tests++; if (ov[0] !== 1'b1 || od[0] !== 32'h93) begin
      n_fail++; $display("FAIL async_first got v=%b 0x%08h exp v=1 0x00000093", ov[0], od[0]);
    end
    tick();
    n_tests++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL async_no_stale got v=%b 0x%08h exp v=0", ov[0], od[0]); end
  endtask

  task automatic test_random();
    for (int d = 0; d < 2; d++) begin
      idle_all();
      for (int c = 0; c < 250; c++) begin
        drive(d, ($urandom % 4) != 0, $urandom, ($urandom % 4) != 0,
              ($urandom % 25) == 0, ($urandom % 40) == 0);
        n_tests++; if (ov[d] !== e_ov(d) || od[d] !== e_od(d) || ir[d] !== e_ir(d) || a_sc(d) !== 16'(m_sc[d])) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d got v=%b 0x%08h r=%b c=%0d exp v=%b 0x%08h r=%b c=%0d",
                   d, c, ov[d], od[d], ir[d], a_sc(d), e_ov(d), e_od(d), e_ir(d), m_sc[d]);
        end
        tick();
      end
      for (int c = 0; c < 3; c++) begin
        drive(d, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
      end
      n_tests++; if (ov[d] !== 1'b0) begin n_fail++; $display("FAIL random_drain dut%0d got v=%b exp 0", d, ov[d]); end
    end
  endtask

  initial begin
    idle_all();
    model_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #1;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_saturate();
    test_noskid();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline stage register that replaces the fixed-field enable/flush latches between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque packed payload of any width with a valid/ready handshake. An optional skid entry gives the upstream stage a registered ready signal, and a synchronous flush inserts a bubble. A saturating stall counter supports hazard-unit debug and performance measurement.

## Interface
- DATA_W, 128, payload width in bits; each stage passes its packed struct cast to this width
- SKID, 1, 1 = two-entry stage with registered in_ready; 0 = single register, combinational in_ready
- RESET_VAL, '0, payload value presented on out_data whenever out_valid=0 (bubble = all-zero NOP)
- CNT_W, 16, stall counter width

- CLK  in  1  rising-edge clock
- nRST  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has a payload
- in_ready  out  1  stage accepts a payload this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  payload presented downstream
- out_ready  in  1  downstream consumes out_data this cycle
- out_data  out  DATA_W  downstream payload
- flush  in  1  synchronous squash of all held and incoming payloads
- clr_cnt  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- A handshake on a port occurs on a rising edge when valid=1 and ready=1 on that port.
- States: EMPTY (no payload), FULL (main entry valid), SKID (main and skid entries valid). SKID=0 never enters SKID.
- EMPTY: in_valid -> main<=in_data, go to FULL.
- FULL, in_valid and out_ready -> main<=in_data, stay in FULL.
- FULL, out_ready only -> go to EMPTY; main<=RESET_VAL.
- FULL, in_valid only -> skid<=in_data, go to SKID. This is reachable only when SKID=1.
- FULL, neither -> hold.
- SKID: out_ready -> main<=skid, skid<=RESET_VAL, go to FULL. Otherwise hold. in_ready=0 in this state.
- out_valid = (state != EMPTY); out_data = main entry. The main entry is always RESET_VAL when EMPTY.
- in_ready: SKID=1 -> (state != SKID), driven from a register. SKID=0 -> (!out_valid || out_ready), combinational.
- flush has top priority. Next state is EMPTY and both entries load RESET_VAL. A payload offered on in_data in the same cycle is dropped. out_ready in that cycle still completes the current downstream handshake.
- Order is strictly FIFO. Payloads are never duplicated or reordered.
- stall_cnt increments on every edge with out_valid=1 and out_ready=0. It saturates at 2^CNT_W-1. The condition is evaluated before flush, so a stalled flush cycle is still counted.
- clr_cnt has priority over increment: stall_cnt<=0.
- Reset values: state EMPTY, out_valid 0, out_data RESET_VAL, in_ready 1, stall_cnt 0, skid RESET_VAL.

## Timing
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 payload per cycle while out_ready=1.
- SKID=1: no combinational path from out_ready to in_ready. One extra payload is absorbed after downstream deasserts ready.
- SKID=0: in_ready depends combinationally on out_ready. Equivalent to the legacy enable/flush latch with enable=in_ready.
- nRST assertion mid-transfer discards all payloads asynchronously. The first input handshake can occur on the first edge after nRST deasserts.
- in_valid may drop without a handshake; the stage does not require it to be held. in_data is sampled only on a handshake.

## Structure
- Add typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pstage_state_t to cpu_types_pkg.
- Add per-stage payload structs (idex_t, exmem_t, ...) and their widths ($bits) to cpu_types_pkg so instantiations size DATA_W from the package.
- Use one sub-module, sat_counter (parameter W; ports CLK, nRST, inc, clr, count), for stall_cnt.
- The existing per-stage interfaces become thin wrappers that pack into in_data and unpack from out_data.

## Test plan
- Reset, then stream 0x1..0x8 with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, first value one cycle after the first input; stall_cnt=0.
- SKID=1: hold out_ready=0 while sending 0xA, 0xB, 0xC -> 0xA and 0xB accepted, in_ready=0 when 0xC is offered. Release out_ready -> outputs 0xA, 0xB, then 0xC; stall_cnt equals the number of stalled cycles.
- In SKID state assert flush with in_valid=1 (data 0xD) -> next cycle out_valid=0, out_data=RESET_VAL, in_ready=1; 0xD never appears.
- CNT_W=4: stall for 20 cycles -> stall_cnt=15. Assert clr_cnt while still stalled -> next cycle stall_cnt=0.
- SKID=0: out_ready=0 with the stage FULL -> in_ready=0 in the same cycle. Raise out_ready with in_valid=1 -> pass-through handshake, no lost or duplicated payloads.
- Assert nRST low for one cycle in SKID state -> out_valid=0, out_data=RESET_VAL immediately; after release, the next payload arrives with no stale data.
